mpu_fault_log: RTL

Fault-record stage directly downstream of the memory-interface MPU. Each single-cycle violation report from the MPU (faulting PC, data address, strobes, direction) is captured into a small FIFO, and a level interrupt is raised toward the CPU. The CPU drains records through a picorv32-style memory-mapped register window on the same bus the MPU serves. Overflow is tracked with a sticky flag and a saturating drop counter.

---
 rtl/mpu_fault_log_if.sv | 27 ++
 rtl/mpu_fault_log.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mpu_fault_log_if.sv
// Bus bundle for mpu_fault_log: MPU violation reports plus the CPU register window.
// The master side is the requester (MPU/CPU); the slave side is the fault log.
interface mpu_fault_log_if;
   logic        fault_valid;
   logic [31:0] fault_pc;
   logic [21:0] fault_addr;
   logic [3:0]  fault_wstrb;

   logic        reg_valid;
   logic        reg_ready;
   logic [21:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic [31:0] reg_rdata;

   modport master (
      output fault_valid, fault_pc, fault_addr, fault_wstrb,
      output reg_valid, reg_addr, reg_wdata, reg_wstrb,
      input  reg_ready, reg_rdata
   );

   modport slave (
      input  fault_valid, fault_pc, fault_addr, fault_wstrb,
      input  reg_valid, reg_addr, reg_wdata, reg_wstrb,
      output reg_ready, reg_rdata
   );
endinterface

// File: rtl/mpu_fault_log.sv
// MPU fault record FIFO with a memory-mapped drain window, sticky overflow,
// saturating drop counter and a level interrupt toward the CPU.
module mpu_fault_log #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [21:0] BASE_ADDR = 22'h3F_FF00
) (
   input  logic                 clk,
   input  logic                 reset,
   mpu_fault_log_if.slave       bus,
   output logic                 irq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   // Record storage: PC plus {wstrb, addr}; contents are don't-care when empty.
   logic [31:0] pc_mem   [DEPTH];
   logic [25:0] info_mem [DEPTH];

   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          irq_en;
   logic [7:0]    drop_cnt;
   logic          ready_q;
   logic [31:0]   rdata_q;

   logic [PW-1:0] rd_ptr_n, wr_ptr_n;
   logic [CW-1:0] count_n;
   logic          overflow_n, irq_en_n, irq_n;
   logic [7:0]    drop_cnt_n;
   logic          hit_c, acc_c, wr_c, stat_wr_c, pop_c, push_c, drop_c, w1c_c, empty_c;
   logic [1:0]    off_c;
   logic [25:0]   head_info_c;
   logic [31:0]   head_pc_c;
   logic [31:0]   rdata_c;
   logic          unused_c;

   assign bus.reg_ready = ready_q;
   assign bus.reg_rdata = rdata_q;
   assign unused_c = ^{bus.reg_addr[1:0], bus.reg_wdata[31:10], bus.reg_wdata[7:0]};

   // Decode of the bus access, FIFO movement and next register state.
   always_comb begin
      hit_c       = (bus.reg_addr[21:4] == BASE_ADDR[21:4]);
      acc_c       = bus.reg_valid & hit_c & ~ready_q;
      wr_c        = acc_c & (|bus.reg_wstrb);
      off_c       = bus.reg_addr[3:2];
      empty_c     = (count == '0);
      stat_wr_c   = wr_c & (off_c == 2'd0) & bus.reg_wstrb[1];
      w1c_c       = stat_wr_c & bus.reg_wdata[8];
      pop_c       = wr_c & (off_c == 2'd3) & ~empty_c;
      push_c      = bus.fault_valid & ((count != CW'(DEPTH)) | pop_c);
      drop_c      = bus.fault_valid & ~push_c;

      rd_ptr_n    = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr_n    = push_c ? wr_ptr + PW'(1) : wr_ptr;
      count_n     = count + CW'(push_c) - CW'(pop_c);
      irq_en_n    = stat_wr_c ? bus.reg_wdata[9] : irq_en;

      // A drop on the same edge as a W1C clear wins over the clear.
      overflow_n  = overflow;
      drop_cnt_n  = drop_cnt;
      if (drop_c) begin
         overflow_n = 1'b1;
         if (w1c_c)
            drop_cnt_n = 8'd1;
         else if (drop_cnt != 8'hFF)
            drop_cnt_n = drop_cnt + 8'd1;
      end else if (w1c_c) begin
         overflow_n = 1'b0;
         drop_cnt_n = 8'd0;
      end

      irq_n       = irq_en_n & ((count_n != '0) | overflow_n);

      head_pc_c   = empty_c ? 32'h0 : pc_mem[rd_ptr];
      head_info_c = empty_c ? 26'h0 : info_mem[rd_ptr];

      // Read data reflects state before this edge's side effects.
      unique case (off_c)
         2'd0:    rdata_c = {8'h00, drop_cnt, 6'h00, irq_en, overflow, 3'h0, 5'(count)};
         2'd1:    rdata_c = head_pc_c;
         2'd2:    rdata_c = {head_info_c[25:22], 3'h0, |head_info_c[25:22], 2'h0,
                             head_info_c[21:0]};
         default: rdata_c = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         irq_en   <= 1'b1;
         drop_cnt <= 8'd0;
         ready_q  <= 1'b0;
         rdata_q  <= 32'h0;
         irq      <= 1'b0;
      end else begin
         rd_ptr   <= rd_ptr_n;
         wr_ptr   <= wr_ptr_n;
         count    <= count_n;
         overflow <= overflow_n;
         irq_en   <= irq_en_n;
         drop_cnt <= drop_cnt_n;
         ready_q  <= acc_c;
         rdata_q  <= acc_c ? rdata_c : 32'h0;
         irq      <= irq_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         pc_mem[wr_ptr]   <= bus.fault_pc;
         info_mem[wr_ptr] <= {bus.fault_wstrb, bus.fault_addr};
      end
   end

endmodule
